// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and instruction field positions for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  // Controller FSM encodings; 2'd3 is unused and recovers to ST_RUN.
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MC_WAIT  = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  // RV32 register field positions.
  localparam int RS1_HI = 19;
  localparam int RS1_LO = 15;
  localparam int RS2_HI = 24;
  localparam int RS2_LO = 20;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 7;

  // Opcodes of the instruction classes this controller cares about.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MULDIV = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Load-use hazard: a load in EX writes a non-zero register that the ID instruction reads.
  function automatic logic load_use_hit(input logic       memread_x,
                                        input logic [4:0] rd_x,
                                        input logic [4:0] rs1_d,
                                        input logic [4:0] rs2_d);
    return memread_x && (rd_x != 5'd0) && ((rd_x == rs1_d) || (rd_x == rs2_d));
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for a 5-stage RISC-V pipeline: load-use, EX redirects,
// multicycle EX ops (start/done handshake with timeout) and dmem wait states.
//
// Handshake with the multicycle unit: mc_req is a one-cycle start pulse issued
// in RUN when the EX instruction needs the unit; the unit answers with a
// one-cycle mc_done pulse when its result is valid. While waiting, the EX
// instruction is frozen and bubbles go into EX/MEM. mc_done outside MC_WAIT is
// ignored. If no mc_done arrives within MC_TIMEOUT wait cycles the op is
// abandoned and mc_err latches until reset.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_d,
  input  logic [31:0]      inst_x,
  input  logic             memread_x,
  input  logic             redirect_x,
  input  logic             mc_op_x,
  input  logic             mc_done,
  input  logic             mem_access_m,
  input  logic             dmem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_x,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_x,
  output logic             flush_m,
  output logic             mc_req,
  output logic             mc_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [7:0] MC_LAST = 8'(MC_TIMEOUT - 1);

  logic [1:0] state_q;
  logic [1:0] state_nxt;
  logic [7:0] mc_cnt;
  logic [7:0] mc_cnt_nxt;
  logic       mc_err_set;
  logic       load_use;

  // Raw (pre-reset-gating) stage controls.
  logic s_f, s_d, s_x, s_m, f_d, f_x, f_m, req;

  // Instruction bits outside the register fields are not needed here.
  logic unused_bits;
  assign unused_bits = ^{inst_d[31:25], inst_d[14:0], inst_x[31:12], inst_x[6:0]};

  assign load_use = load_use_hit(memread_x, inst_x[RD_HI:RD_LO],
                                 inst_d[RS1_HI:RS1_LO], inst_d[RS2_HI:RS2_LO]);

  // Next-state and stage-control decode; priority order matters in RUN.
  always_comb begin
    state_nxt  = state_q;
    mc_cnt_nxt = mc_cnt;
    mc_err_set = 1'b0;
    s_f = 1'b0; s_d = 1'b0; s_x = 1'b0; s_m = 1'b0;
    f_d = 1'b0; f_x = 1'b0; f_m = 1'b0; req = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_access_m && !dmem_ready) begin
          s_f = 1'b1; s_d = 1'b1; s_x = 1'b1; s_m = 1'b1;
          state_nxt = ST_MEM_WAIT;
        end else if (mc_op_x) begin
          req = 1'b1;
          s_f = 1'b1; s_d = 1'b1; s_x = 1'b1; f_m = 1'b1;
          mc_cnt_nxt = 8'd0;
          state_nxt  = ST_MC_WAIT;
        end else if (redirect_x) begin
          f_d = 1'b1; f_x = 1'b1;
        end else if (load_use) begin
          // Single-cycle: the load reaches MEM next cycle and forwarding takes over.
          s_f = 1'b1; s_d = 1'b1; f_x = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        if (mc_done) begin
          state_nxt = ST_RUN;
        end else if (mc_cnt == MC_LAST) begin
          mc_err_set = 1'b1;
          state_nxt  = ST_RUN;
        end else begin
          s_f = 1'b1; s_d = 1'b1; s_x = 1'b1; f_m = 1'b1;
          mc_cnt_nxt = mc_cnt + 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = ST_RUN;
        end else begin
          s_f = 1'b1; s_d = 1'b1; s_x = 1'b1; s_m = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Controls are forced low while reset is asserted, independent of state.
  assign stall_f = rst_n & s_f;
  assign stall_d = rst_n & s_d;
  assign stall_x = rst_n & s_x;
  assign stall_m = rst_n & s_m;
  assign flush_d = rst_n & f_d;
  assign flush_x = rst_n & f_x;
  assign flush_m = rst_n & f_m;
  assign mc_req  = rst_n & req;
  assign state   = state_q;

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      mc_cnt  <= 8'd0;
      mc_err  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      mc_cnt  <= mc_cnt_nxt;
      if (mc_err_set) begin
        mc_err <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_f),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: a RUN-state vector table plus
// hand-written multicycle, timeout, priority and mid-wait reset sequences.
module tb_pipeline_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]      inst_d, inst_x;
  logic             memread_x, redirect_x, mc_op_x, mc_done, mem_access_m, dmem_ready;
  logic             stall_f, stall_d, stall_x, stall_m, flush_d, flush_x, flush_m, mc_req, mc_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  logic       sat_inc;
  logic [2:0] sat_count;

  pipeline_stall_ctrl #(.MC_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .inst_x(inst_x),
    .memread_x(memread_x), .redirect_x(redirect_x), .mc_op_x(mc_op_x), .mc_done(mc_done),
    .mem_access_m(mem_access_m), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_x(stall_x), .stall_m(stall_m),
    .flush_d(flush_d), .flush_x(flush_x), .flush_m(flush_m), .mc_req(mc_req),
    .mc_err(mc_err), .state(state), .stall_cnt(stall_cnt)
  );

  // Narrow instance to reach the saturation point quickly.
  sat_counter #(.W(3)) u_sat (.clk(clk), .rst_n(rst_n), .inc(sat_inc), .count(sat_count));

  // Input contract and no stall/flush overlap on the same stage.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(mc_op_x && redirect_x)) else $error("mc_op_x and redirect_x both high");
      assert (!(stall_d && flush_d) && !(stall_x && flush_x) && !(stall_m && flush_m))
        else $error("stall and flush on the same stage");
    end
  end

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  int exp_cnt    = 0;
  logic [7:0] exp_q[$];

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, OP_MULDIV};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, OP_LOAD};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit order: stall_f stall_d stall_x stall_m flush_d flush_x flush_m mc_req.
  task automatic chk_out(input string name, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    chk(name, {24'd0, stall_f, stall_d, stall_x, stall_m, flush_d, flush_x, flush_m, mc_req},
        {24'd0, e});
    if (e[7] && rst_n) exp_cnt++;
  endtask

  task automatic idle();
    inst_d = 32'h0000_0013; inst_x = 32'h0000_0013;
    memread_x = 0; redirect_x = 0; mc_op_x = 0; mc_done = 0;
    mem_access_m = 0; dmem_ready = 0; sat_inc = 0;
  endtask

  // Advance one cycle; land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] inst_d;
    logic [31:0] inst_x;
    logic        memread_x, redirect_x, mc_op_x, mc_done, mem_access_m, dmem_ready;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[9];

  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b1100_0100;
  localparam logic [7:0] O_RED  = 8'b0000_1100;
  localparam logic [7:0] O_MC0  = 8'b1110_0011;
  localparam logic [7:0] O_MCW  = 8'b1110_0010;
  localparam logic [7:0] O_MEM  = 8'b1111_0000;

  initial begin
    vecs[0] = '{"lu_rs1",     r_type(7'd0,5'd6,5'd5,5'd7), lw(5'd5,5'd1), 1,0,0,0,0,0, O_LU};
    vecs[1] = '{"lu_rs2",     r_type(7'd0,5'd6,5'd7,5'd5), lw(5'd5,5'd1), 1,0,0,0,0,0, O_LU};
    vecs[2] = '{"lu_nomatch", r_type(7'd0,5'd6,5'd1,5'd2), lw(5'd5,5'd1), 1,0,0,0,0,0, O_NONE};
    vecs[3] = '{"lu_x0",      r_type(7'd0,5'd1,5'd0,5'd0), lw(5'd0,5'd1), 1,0,0,0,0,0, O_NONE};
    vecs[4] = '{"no_load",    r_type(7'd0,5'd6,5'd5,5'd7), r_type(7'd0,5'd5,5'd1,5'd2), 0,0,0,0,0,0, O_NONE};
    vecs[5] = '{"redirect",   r_type(7'd0,5'd6,5'd1,5'd2), r_type(7'd0,5'd3,5'd1,5'd2), 0,1,0,0,0,0, O_RED};
    vecs[6] = '{"redir_lu",   r_type(7'd0,5'd6,5'd5,5'd7), lw(5'd5,5'd1), 1,1,0,0,0,0, O_RED};
    vecs[7] = '{"done_in_run",32'h0000_0013, 32'h0000_0013, 0,0,0,1,0,0, O_NONE};
    vecs[8] = '{"mem_rdy_lu", r_type(7'd0,5'd6,5'd5,5'd7), lw(5'd5,5'd1), 1,0,0,0,1,1, O_LU};

    // ---- reset: inputs that would stall must be masked ----
    idle();
    rst_n = 0;
    mem_access_m = 1; dmem_ready = 0; mc_op_x = 1;
    #1;
    chk_out("reset_outs", O_NONE);
    #21;
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_err", {31'd0, mc_err}, 32'd0);
    idle();
    rst_n = 1;
    exp_cnt = 0;
    tick();

    // ---- table: single RUN cycles ----
    for (int i = 0; i < 9; i++) begin
      inst_d = vecs[i].inst_d; inst_x = vecs[i].inst_x;
      memread_x = vecs[i].memread_x; redirect_x = vecs[i].redirect_x;
      mc_op_x = vecs[i].mc_op_x; mc_done = vecs[i].mc_done;
      mem_access_m = vecs[i].mem_access_m; dmem_ready = vecs[i].dmem_ready;
      #1;
      chk_out(vecs[i].name, vecs[i].exp_out);
      tick();
      idle();
      #1;
      chk({vecs[i].name, "_after"}, {24'd0, stall_f, stall_d, stall_x, stall_m,
          flush_d, flush_x, flush_m, mc_req}, 32'd0);
      chk({vecs[i].name, "_state"}, {30'd0, state}, {30'd0, ST_RUN});
    end
    chk("cnt_table", {16'd0, stall_cnt}, exp_cnt);

    // ---- multicycle op, done at T5 ----
    inst_x = r_type(F7_MULDIV, 5'd4, 5'd1, 5'd2); mc_op_x = 1;
    #1; chk_out("mc_t0", O_MC0); tick();
    for (int t = 1; t <= 4; t++) begin
      #1; chk_out("mc_wait", O_MCW);
      chk("mc_wait_state", {30'd0, state}, {30'd0, ST_MC_WAIT});
      tick();
    end
    mc_done = 1;
    #1; chk_out("mc_t5", O_NONE); tick();
    idle();
    #1; chk("mc_t6_state", {30'd0, state}, {30'd0, ST_RUN});
    chk_out("mc_t6", O_NONE);
    chk("mc_cnt", {16'd0, stall_cnt}, exp_cnt);
    chk("mc_noerr", {31'd0, mc_err}, 32'd0);
    tick();

    // ---- timeout: MC_TIMEOUT=8, no done ----
    inst_x = r_type(F7_MULDIV, 5'd4, 5'd1, 5'd2); mc_op_x = 1;
    #1; chk_out("to_t0", O_MC0); tick();
    for (int t = 1; t <= 7; t++) begin
      #1; chk_out("to_wait", O_MCW); tick();
    end
    #1; chk_out("to_t8", O_NONE);
    chk("to_t8_err", {31'd0, mc_err}, 32'd0);
    tick();
    idle();
    #1; chk("to_t9_err", {31'd0, mc_err}, 32'd1);
    chk("to_t9_state", {30'd0, state}, {30'd0, ST_RUN});
    tick(); tick();
    chk("to_sticky", {31'd0, mc_err}, 32'd1);
    chk("to_cnt", {16'd0, stall_cnt}, exp_cnt);

    // ---- priority: dmem wait beats mc_op ----
    mem_access_m = 1; dmem_ready = 0; mc_op_x = 1;
    inst_x = r_type(F7_MULDIV, 5'd4, 5'd1, 5'd2);
    #1; chk_out("pri_t0", O_MEM); tick();
    for (int t = 1; t <= 2; t++) begin
      #1; chk_out("pri_wait", O_MEM);
      chk("pri_state", {30'd0, state}, {30'd0, ST_MEM_WAIT});
      tick();
    end
    dmem_ready = 1;
    #1; chk_out("pri_release", O_NONE); tick();
    mem_access_m = 0; dmem_ready = 0;
    #1; chk_out("pri_mc_issue", O_MC0); tick();
    mc_done = 1;
    #1; chk_out("pri_mc_done", O_NONE); tick();
    idle();
    #1; chk("pri_cnt", {16'd0, stall_cnt}, exp_cnt);

    // ---- async reset in the middle of a dmem wait ----
    mem_access_m = 1; dmem_ready = 0;
    #1; chk_out("rst_enter", O_MEM); tick();
    chk("rst_pre_state", {30'd0, state}, {30'd0, ST_MEM_WAIT});
    #2 rst_n = 0;
    #1;
    chk_out("rst_mid_outs", O_NONE);
    chk("rst_mid_state", {30'd0, state}, 32'd0);
    chk("rst_mid_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_mid_err", {31'd0, mc_err}, 32'd0);
    exp_cnt = 0;
    @(posedge clk); #1;
    idle();
    rst_n = 1;
    #1;
    chk_out("rst_post_idle", O_NONE);
    tick();
    inst_d = r_type(7'd0, 5'd6, 5'd5, 5'd7); inst_x = lw(5'd5, 5'd1); memread_x = 1;
    #1; chk_out("rst_post_lu", O_LU); tick();
    idle();
    #1; chk("rst_post_cnt", {16'd0, stall_cnt}, exp_cnt);

    // ---- counter saturation ----
    sat_inc = 1;
    for (int t = 0; t < 6; t++) tick();
    chk("sat_6", {29'd0, sat_count}, 32'd6);
    for (int t = 0; t < 4; t++) tick();
    chk("sat_hold", {29'd0, sat_count}, 32'd7);
    sat_inc = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
